pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central sequencer for the five-stage LC-3b pipeline. Drives load and bubble enables for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC. Stalls the pipeline on outstanding instruction or data memory accesses and on load-use hazards, and flushes younger stages on a taken branch resolved in MEM. Also performs the post-reset flush of the unreset pipeline registers and keeps a saturating stall-cycle counter.

## Interface
- FLUSH_CYCLES, 4, cycles of all-stage bubble insertion after reset deasserts (≥1)
- CNT_W, 16, width of stall_count
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- imem_resp  in  1  one-cycle pulse: fetch data valid
- dmem_req  in  1  MEM-stage instruction needs memory (decoded from EX/MEM cword)
- dmem_resp  in  1  one-cycle pulse: data access complete
- load_use  in  1  ID/EX holds a load whose dest matches an IF/ID source
- branch_taken  in  1  MEM stage redirects control flow
- imem_read  out  1  fetch request
- dmem_en  out  1  data access enable
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  register load enables
- bubble_if_id, bubble_id_ex, bubble_ex_mem, bubble_mem_wb  out  1 each  register loads NOP cword instead of upstream; meaningful only with its load
- pc_sel_target  out  1  PC mux selects branch target
- fetch_hold_load  out  1  capture fetch data into hold buffer
- fetch_hold_sel  out  1  IF/ID input taken from hold buffer
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- States: INIT, RUN, STALL. All outputs except stall_count are combinational from state, flags and inputs.
- Flags: i_done and d_done are registered and record a response that has already been received in the current stall.
- Derived signals:
  - i_ok = imem_resp | i_done
  - d_ok = ~dmem_req | dmem_resp | d_done
  - adv = (RUN|STALL) & i_ok & d_ok
- INIT: active for FLUSH_CYCLES cycles, counted by an internal counter.
  - All four register loads = 1 and all four bubbles = 1.
  - load_pc = 0, imem_read = 0, dmem_en = 0.
  - imem_resp and dmem_resp are ignored.
  - When the count ends, go to RUN.
- RUN/STALL, memory requests:
  - imem_read = ~i_done
  - dmem_en = dmem_req & ~d_done
- RUN/STALL with adv = 0:
  - All loads = 0. Next state is STALL.
  - i_done is set on imem_resp; d_done is set on dmem_resp.
  - fetch_hold_load = imem_resp.
- RUN/STALL with adv = 1: next state is RUN, both flags are cleared, fetch_hold_sel = i_done. Priority:
  - branch_taken: all loads = 1, load_pc = 1, pc_sel_target = 1; bubble_if_id, bubble_id_ex and bubble_ex_mem = 1. load_use is ignored.
  - else load_use: load_pc = 0, load_if_id = 0; load_id_ex = 1 with bubble_id_ex = 1; load_ex_mem = 1, load_mem_wb = 1. The fetched word is discarded and refetched from the unchanged PC.
  - else: all loads = 1, all bubbles = 0.
- stall_count: increments by 1 in each RUN/STALL cycle where adv = 0, or adv = 1 with load_use and no branch_taken. It saturates at 2^CNT_W−1 and is not cleared by INIT exit.

## Timing
- Reset (sampled high at an edge) forces:
  - state INIT with the flush counter at 0
  - i_done = d_done = 0
  - stall_count = 0
- While reset is held, outputs follow INIT values (all loads/bubbles 1, requests 0).
- Reset during STALL drops any in-flight access: requests deassert the next cycle, and a late response arriving in INIT is ignored. The memories abort on request deassert.
- First RUN cycle is FLUSH_CYCLES cycles after the last reset-high edge.
- Zero-latency advance: a response in cycle N with the other side ready gives adv = 1 in cycle N.
- imem_resp and dmem_resp arriving in the same cycle give adv in that cycle; the flags are never set.
- Responses in different cycles: the first is latched, and the second gives adv.
- branch_taken together with load_use: the branch wins.
- branch_taken during a stall takes effect only on the adv cycle.
- After adv with i_done = 1, imem_read reasserts the next cycle for the new PC.

## Structure
- Add to lc3b_types:
  - pipeline_ctrl_state_t enum {INIT, RUN, STALL}
  - NOP_CWORD constant (16'h0000), which the datapath muxes in on bubble.
- Sub-module sat_counter #(width) for stall_count. The flush counter stays inline.

## Test plan
- Reset for 2 cycles, release → load_pc = 0 and all bubbles = 1 for exactly 4 cycles, then RUN with imem_read = 1; stall_count = 0.
- imem_resp in the first RUN cycle, dmem_req = 0 → all loads 1, no bubbles, state RUN, stall_count unchanged.
- dmem_req = 1; imem_resp at cycle 2, dmem_resp at cycle 5:
  - fetch_hold_load = 1 at cycle 2.
  - imem_read = 0 for cycles 3–5.
  - adv at cycle 5 with fetch_hold_sel = 1.
  - stall_count = 3.
- load_use = 1 with imem_resp → load_pc = 0, load_if_id = 0, load_id_ex = 1 with bubble_id_ex = 1; stall_count +1.
- branch_taken = 1 and load_use = 1 with imem_resp → load_pc = 1, pc_sel_target = 1; bubble_if_id, bubble_id_ex and bubble_ex_mem = 1; bubble_mem_wb = 0.
- CNT_W = 2 with 5 stall cycles → stall_count = 3. Then reset mid-stall with dmem_resp in the following cycle → state INIT, flags 0, response ignored, stall_count = 0.

Source files
------------

// File: rtl/lc3b_types.sv
// lc3b_types: shared types and constants for the LC-3b pipeline.
//   pipeline_ctrl_state_t : sequencer states (INIT flush, RUN, STALL)
//   NOP_CWORD             : control word the datapath muxes into a
//                           pipeline register when its bubble is set
package lc3b_types;

    typedef enum logic [1:0] {
        INIT  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10
    } pipeline_ctrl_state_t;

    localparam logic [15:0] NOP_CWORD = 16'h0000;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones value.
//   clk   in          rising-edge clock
//   reset in          synchronous active-high clear
//   inc   in          count this cycle
//   count out [width] current count (registered)
module sat_counter #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [width-1:0] count
);

    logic [width-1:0] count_r;

    // count register: clears on reset, holds once every bit is set
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (inc && (count_r != '1)) begin
            count_r <= count_r + width'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central sequencer of the five-stage LC-3b pipeline.
// Generates PC / pipeline register load and bubble enables, stalls on
// outstanding instruction/data memory accesses and load-use hazards,
// flushes younger stages on a branch taken in MEM, runs a post-reset
// all-bubble flush and keeps a saturating stall-cycle counter.
// Ports:
//   clk, reset (sync, active high)
//   imem_resp, dmem_req, dmem_resp, load_use, branch_taken : status inputs
//   imem_read, dmem_en              : memory requests
//   load_pc, load_<stage>           : register load enables
//   bubble_<stage>                  : load NOP_CWORD instead of upstream
//   pc_sel_target                   : PC mux picks branch target
//   fetch_hold_load, fetch_hold_sel : fetch hold buffer capture / select
//   stall_count [CNT_W]             : saturating stall-cycle count
module pipeline_ctrl
    import lc3b_types::*;
#(
    parameter int FLUSH_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             load_use,
    input  logic             branch_taken,
    output logic             imem_read,
    output logic             dmem_en,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             bubble_if_id,
    output logic             bubble_id_ex,
    output logic             bubble_ex_mem,
    output logic             bubble_mem_wb,
    output logic             pc_sel_target,
    output logic             fetch_hold_load,
    output logic             fetch_hold_sel,
    output logic [CNT_W-1:0] stall_count
);

    localparam int               FC_W       = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0]  FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);

    pipeline_ctrl_state_t state_r, state_next_s;
    logic [FC_W-1:0]      flush_cnt_r;
    logic                 i_done_r, d_done_r;
    logic                 active_s, i_ok_s, d_ok_s, adv_s, stall_inc_s;

    // A response already seen in this stall counts as satisfied; a side
    // with no data request is trivially satisfied.
    assign active_s    = (state_r == RUN) || (state_r == STALL);
    assign i_ok_s      = imem_resp | i_done_r;
    assign d_ok_s      = ~dmem_req | dmem_resp | d_done_r;
    assign adv_s       = active_s & i_ok_s & d_ok_s;
    // A load-use bubble costs a cycle just like a memory wait, unless a
    // taken branch squashes the dependent instruction anyway.
    assign stall_inc_s = active_s & (~adv_s | (load_use & ~branch_taken));

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= INIT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // post-reset flush counter; stops at its last value once RUN is reached
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt_r <= '0;
        end else if ((state_r == INIT) && (flush_cnt_r != FLUSH_LAST)) begin
            flush_cnt_r <= flush_cnt_r + FC_W'(1);
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    // response-received flags: set while waiting, cleared on advance and in INIT
    always_ff @(posedge clk) begin
        if (reset) begin
            i_done_r <= 1'b0;
            d_done_r <= 1'b0;
        end else if (active_s && !adv_s) begin
            i_done_r <= i_done_r | imem_resp;
            d_done_r <= d_done_r | dmem_resp;
        end else begin
            i_done_r <= 1'b0;
            d_done_r <= 1'b0;
        end
    end

    // next-state and pipeline control decode
    always_comb begin
        state_next_s    = state_r;
        imem_read       = 1'b0;
        dmem_en         = 1'b0;
        load_pc         = 1'b0;
        load_if_id      = 1'b0;
        load_id_ex      = 1'b0;
        load_ex_mem     = 1'b0;
        load_mem_wb     = 1'b0;
        bubble_if_id    = 1'b0;
        bubble_id_ex    = 1'b0;
        bubble_ex_mem   = 1'b0;
        bubble_mem_wb   = 1'b0;
        pc_sel_target   = 1'b0;
        fetch_hold_load = 1'b0;
        fetch_hold_sel  = 1'b0;
        case (state_r)
            INIT: begin
                // Pipeline registers are not reset: clock NOPs through all of them.
                load_if_id    = 1'b1;
                load_id_ex    = 1'b1;
                load_ex_mem   = 1'b1;
                load_mem_wb   = 1'b1;
                bubble_if_id  = 1'b1;
                bubble_id_ex  = 1'b1;
                bubble_ex_mem = 1'b1;
                bubble_mem_wb = 1'b1;
                if (flush_cnt_r == FLUSH_LAST) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = INIT;
                end
            end
            RUN, STALL: begin
                imem_read = ~i_done_r;
                dmem_en   = dmem_req & ~d_done_r;
                if (!adv_s) begin
                    // Freeze everything; park an early fetch word in the hold buffer.
                    state_next_s    = STALL;
                    fetch_hold_load = imem_resp;
                end else begin
                    state_next_s   = RUN;
                    fetch_hold_sel = i_done_r;
                    if (branch_taken) begin
                        load_pc       = 1'b1;
                        load_if_id    = 1'b1;
                        load_id_ex    = 1'b1;
                        load_ex_mem   = 1'b1;
                        load_mem_wb   = 1'b1;
                        pc_sel_target = 1'b1;
                        bubble_if_id  = 1'b1;
                        bubble_id_ex  = 1'b1;
                        bubble_ex_mem = 1'b1;
                    end else if (load_use) begin
                        // Hold IF/ID and PC, insert a NOP behind the load;
                        // the fetched word is dropped and refetched.
                        load_id_ex   = 1'b1;
                        bubble_id_ex = 1'b1;
                        load_ex_mem  = 1'b1;
                        load_mem_wb  = 1'b1;
                    end else begin
                        load_pc     = 1'b1;
                        load_if_id  = 1'b1;
                        load_id_ex  = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                    end
                end
            end
            default: begin
                state_next_s = INIT;
            end
        endcase
    end

    sat_counter #(.width(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc_s),
        .count (stall_count)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: randomized self-checking bench for pipeline_ctrl.
// Two instances (CNT_W = 16 and CNT_W = 2) share all inputs; a
// transaction-level model of the pipeline rules predicts every output.
module tb_pipeline_ctrl;

    localparam int FLUSH = 4;

    logic clk = 1'b0;
    logic reset = 1'b0, imem_resp = 1'b0, dmem_req = 1'b0, dmem_resp = 1'b0;
    logic load_use = 1'b0, branch_taken = 1'b0;

    logic        ir_a, de_a, lpc_a, lif_a, lid_a, lex_a, lmw_a;
    logic        bif_a, bid_a, bex_a, bmw_a, pcs_a, hl_a, hs_a;
    logic [15:0] sc_a;
    logic        ir_b, de_b, lpc_b, lif_b, lid_b, lex_b, lmw_b;
    logic        bif_b, bid_b, bex_b, bmw_b, pcs_b, hl_b, hs_b;
    logic [1:0]  sc_b;

    always #5 clk = ~clk;

    pipeline_ctrl #(.FLUSH_CYCLES(FLUSH), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .imem_resp(imem_resp), .dmem_req(dmem_req),
        .dmem_resp(dmem_resp), .load_use(load_use), .branch_taken(branch_taken),
        .imem_read(ir_a), .dmem_en(de_a), .load_pc(lpc_a), .load_if_id(lif_a),
        .load_id_ex(lid_a), .load_ex_mem(lex_a), .load_mem_wb(lmw_a),
        .bubble_if_id(bif_a), .bubble_id_ex(bid_a), .bubble_ex_mem(bex_a),
        .bubble_mem_wb(bmw_a), .pc_sel_target(pcs_a), .fetch_hold_load(hl_a),
        .fetch_hold_sel(hs_a), .stall_count(sc_a));

    pipeline_ctrl #(.FLUSH_CYCLES(FLUSH), .CNT_W(2)) dut_w2 (
        .clk(clk), .reset(reset), .imem_resp(imem_resp), .dmem_req(dmem_req),
        .dmem_resp(dmem_resp), .load_use(load_use), .branch_taken(branch_taken),
        .imem_read(ir_b), .dmem_en(de_b), .load_pc(lpc_b), .load_if_id(lif_b),
        .load_id_ex(lid_b), .load_ex_mem(lex_b), .load_mem_wb(lmw_b),
        .bubble_if_id(bif_b), .bubble_id_ex(bid_b), .bubble_ex_mem(bex_b),
        .bubble_mem_wb(bmw_b), .pc_sel_target(pcs_b), .fetch_hold_load(hl_b),
        .fetch_hold_sel(hs_b), .stall_count(sc_b));

    // packed views: [13] imem_read [12] dmem_en [11:7] loads pc..mem_wb
    // [6:3] bubbles if_id..mem_wb [2] pc_sel [1] hold_load [0] hold_sel
    wire [13:0] act_a = {ir_a, de_a, lpc_a, lif_a, lid_a, lex_a, lmw_a,
                         bif_a, bid_a, bex_a, bmw_a, pcs_a, hl_a, hs_a};
    wire [13:0] act_b = {ir_b, de_b, lpc_b, lif_b, lid_b, lex_b, lmw_b,
                         bif_b, bid_b, bex_b, bmw_b, pcs_b, hl_b, hs_b};

    int checks = 0;
    int errors = 0;

    // model state: flush cycles left, responses already collected, stall totals
    int flush_left  = 0;
    bit got_i       = 1'b0;
    bit got_d       = 1'b0;
    int st16        = 0;
    int st2         = 0;
    bit model_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit m_adv();
        return (flush_left == 0) && (imem_resp || got_i) &&
               (!dmem_req || dmem_resp || got_d);
    endfunction

    function automatic int sat_inc(input int v, input int max);
        return (v < max) ? v + 1 : v;
    endfunction

    // model update at the clock edge, from the inputs the DUT samples
    always @(posedge clk) begin
        if (reset) begin
            flush_left  <= FLUSH;
            got_i       <= 1'b0;
            got_d       <= 1'b0;
            st16        <= 0;
            st2         <= 0;
            model_valid <= 1'b1;
        end else if (model_valid) begin
            if (flush_left > 0) begin
                flush_left <= flush_left - 1;
            end else if (!m_adv()) begin
                got_i <= got_i | imem_resp;
                got_d <= got_d | dmem_resp;
                st16  <= sat_inc(st16, 65535);
                st2   <= sat_inc(st2, 3);
            end else begin
                got_i <= 1'b0;
                got_d <= 1'b0;
                if (load_use && !branch_taken) begin
                    st16 <= sat_inc(st16, 65535);
                    st2  <= sat_inc(st2, 3);
                end
            end
        end
    end

    task automatic compare_cycle();
        bit          init, adv;
        logic [1:0]  ereq;
        logic [4:0]  el;
        logic [3:0]  eb;
        logic        epc;
        logic [13:0] a;
        string       t;
        init = (flush_left > 0);
        adv  = m_adv();
        ereq = 2'b00; el = 5'b00000; eb = 4'b0000; epc = 1'b0;
        if (init) begin
            el = 5'b01111; eb = 4'b1111;
        end else begin
            ereq = {!got_i, dmem_req && !got_d};
            if (!adv)              el = 5'b00000;
            else if (branch_taken) begin el = 5'b11111; eb = 4'b1110; epc = 1'b1; end
            else if (load_use)     begin el = 5'b00111; eb = 4'b0100; end
            else                   begin el = 5'b11111; eb = 4'b0000; end
        end
        for (int k = 0; k < 2; k++) begin
            a = (k == 0) ? act_a : act_b;
            t = (k == 0) ? "w16" : "w2";
            chk({t, "_requests"}, {30'd0, a[13:12]}, {30'd0, ereq});
            chk({t, "_loads"}, {27'd0, a[11:7]}, {27'd0, el});
            chk({t, "_bubbles"}, {28'd0, a[6:3] & el[3:0]}, {28'd0, eb & el[3:0]});
            if (el[4]) chk({t, "_pc_sel_target"}, {31'd0, a[2]}, {31'd0, epc});
            if (!init && !adv) chk({t, "_fetch_hold_load"}, {31'd0, a[1]}, {31'd0, imem_resp});
            if (adv) chk({t, "_fetch_hold_sel"}, {31'd0, a[0]}, {31'd0, got_i});
        end
        chk("w16_stall_count", {16'd0, sc_a}, st16);
        chk("w2_stall_count", {30'd0, sc_b}, st2);
    endtask

    // per-cycle comparison on the falling edge, away from input changes
    always @(negedge clk) begin
        if (model_valid) compare_cycle();
    end

    // apply one cycle of inputs just after the rising edge, then settle
    task automatic drive(input logic r, input logic ir, input logic dq,
                         input logic dr, input logic lu, input logic bt);
        @(posedge clk);
        #1;
        reset = r; imem_resp = ir; dmem_req = dq;
        dmem_resp = dr; load_use = lu; branch_taken = bt;
        #2;
    endtask

    initial begin
        // reset for two cycles, then four flush cycles
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        chk("reset_bubble_mem_wb", {31'd0, bmw_a}, 32'd1);
        for (int i = 0; i < FLUSH; i++) begin
            drive(0, 1, 1, 1, 0, 0);
            chk("init_load_pc", {31'd0, lpc_a}, 32'd0);
            chk("init_bubble_if_id", {31'd0, bif_a}, 32'd1);
            chk("init_imem_read", {31'd0, ir_a}, 32'd0);
        end
        // first RUN cycle: fetch completes, no data access
        drive(0, 1, 0, 0, 0, 0);
        chk("run_imem_read", {31'd0, ir_a}, 32'd1);
        chk("run_load_if_id", {31'd0, lif_a}, 32'd1);
        chk("run_bubble_if_id", {31'd0, bif_a}, 32'd0);
        chk("run_stall_count", {16'd0, sc_a}, 32'd0);
        // fetch returns first, data three cycles later
        drive(0, 1, 1, 0, 0, 0);
        chk("split_hold_load", {31'd0, hl_a}, 32'd1);
        chk("split_load_pc_wait", {31'd0, lpc_a}, 32'd0);
        drive(0, 0, 1, 0, 0, 0);
        chk("split_imem_read_c3", {31'd0, ir_a}, 32'd0);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0);
        chk("split_imem_read_c5", {31'd0, ir_a}, 32'd0);
        chk("split_adv_load_pc", {31'd0, lpc_a}, 32'd1);
        chk("split_hold_sel", {31'd0, hs_a}, 32'd1);
        // load-use hazard
        drive(0, 1, 0, 0, 1, 0);
        chk("split_stall_count", {16'd0, sc_a}, 32'd3);
        chk("lu_imem_read", {31'd0, ir_a}, 32'd1);
        chk("lu_load_pc", {31'd0, lpc_a}, 32'd0);
        chk("lu_load_if_id", {31'd0, lif_a}, 32'd0);
        chk("lu_load_id_ex", {31'd0, lid_a}, 32'd1);
        chk("lu_bubble_id_ex", {31'd0, bid_a}, 32'd1);
        // branch beats load-use
        drive(0, 1, 0, 0, 1, 1);
        chk("lu_stall_count", {16'd0, sc_a}, 32'd4);
        chk("w2_sat_stall_count", {30'd0, sc_b}, 32'd3);
        chk("br_load_pc", {31'd0, lpc_a}, 32'd1);
        chk("br_pc_sel", {31'd0, pcs_a}, 32'd1);
        chk("br_bubbles", {28'd0, bif_a, bid_a, bex_a, bmw_a}, 32'hE);
        // five idle stall cycles
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        chk("idle_stall_count", {16'd0, sc_a}, 32'd9);
        chk("idle_w2_stall_count", {30'd0, sc_b}, 32'd3);
        // reset in the middle of a stall, late data response ignored
        drive(1, 0, 1, 0, 0, 0);
        chk("rst_stall_dmem_en", {31'd0, de_a}, 32'd1);
        drive(0, 0, 1, 1, 0, 0);
        chk("rst_init_dmem_en", {31'd0, de_a}, 32'd0);
        chk("rst_init_imem_read", {31'd0, ir_a}, 32'd0);
        chk("rst_stall_count", {16'd0, sc_a}, 32'd0);
        chk("rst_w2_stall_count", {30'd0, sc_b}, 32'd0);
        for (int i = 0; i < FLUSH - 1; i++) drive(0, 0, 1, 1, 0, 0);
        // flags must be clear: clean advance without hold buffer
        drive(0, 1, 0, 0, 0, 0);
        chk("post_rst_load_if_id", {31'd0, lif_a}, 32'd1);
        chk("post_rst_hold_sel", {31'd0, hs_a}, 32'd0);
        // randomized traffic, with occasional resets
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 99) < 30),
                  ($urandom_range(0, 99) < 50),
                  ($urandom_range(0, 99) < 30),
                  ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 15));
        end
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #6;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
